datapath_controller: RTL and testbench
======================================

Name: datapath_controller

Overview:
- Sequencer driving the register-file/ALU datapath: accepts 16-bit instructions over a valid/ready handshake and generates per-cycle datapath controls (Op, RAA, RAB, WA, Wen, Sel, Ctrl).
- Captures the datapath Flag into a sticky condition bit, which supports conditional (predicated) execution.
- Sits between the instruction source (testbench or instruction memory) and the datapath; it is the initiating side of the datapath control interface.

Parameters:
- INSTR_W, 16, instruction width; fixed format below, other values are unsupported.
- CNT_W, 16, width of the retired and squashed counters.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction available
- instr  in  INSTR_W  instruction word
- instr_ready  out  1  controller can accept an instruction
- Flag  in  1  datapath flag (ADD carry / SUB borrow / EQ result)
- Op  out  3  ALU opcode to datapath
- RAA  out  4  read address A
- RAB  out  4  read address B
- WA  out  4  write address
- Wen  out  1  register-file write enable
- Sel  out  4  InPort byte select (0..7) for LOAD
- Ctrl  out  8  misc controls: [0] output-latch enable, [1] write-source = InPort, [7:2] = 0
- flag_q  out  1  sticky condition flag
- retired  out  CNT_W  count of executed (non-squashed) instructions, wraps
- squashed  out  CNT_W  count of squashed instructions, wraps

Behaviour:
- Instruction format:
  - [15] cond
  - [14:12] opcode
  - [11:8] WA
  - [7:4] RAA
  - [3:0] RAB
- Opcodes:
  - 000 ADD, 001 SUB, 011 AND, 100 MOV (Y = A): write register WA; Op = opcode.
  - 010 EQ: no write; updates flag only.
  - 101 LOAD: write WA from InPort byte; Sel = {1'b0, RAB[2:0]}; Ctrl[1] = 1; Op = 100.
  - 110 OUT: Op = 100, RAA = source register; Ctrl[0] = 1; no write.
  - 111 NOP: no datapath effect.
- Reset values: all outputs 0 except instr_ready = 1; flag_q = 0; counters = 0; FSM in IDLE. Reset mid-instruction aborts it with no Wen pulse.
- FSM: IDLE -> ISSUE -> COMMIT -> IDLE.
  - IDLE: instr_ready = 1. On instr_valid && instr_ready, latch instr and go to ISSUE. All datapath outputs are 0.
  - ISSUE (1 cycle): drive Op, RAA, RAB, WA, Sel, Ctrl[1] from the latched instr; Wen = 0, Ctrl[0] = 0.
  - COMMIT (1 cycle): hold ISSUE values; Wen = 1 for write-class ops; Ctrl[0] = 1 for OUT.
    - At the end of COMMIT, flag_q <= Flag for ADD/SUB/EQ; all other ops leave it unchanged.
    - retired increments.
- Latency: handshake at edge t gives ISSUE in cycle t+1, COMMIT in cycle t+2, and instr_ready = 1 again in cycle t+3. Throughput is one instruction per 3 cycles. instr_ready is low in ISSUE and COMMIT.
- Predication: if cond = 1 and flag_q = 0 at the handshake, the instruction is squashed.
  - It still traverses ISSUE and COMMIT.
  - Wen = 0, Ctrl = 0, flag_q unchanged.
  - squashed increments instead of retired.
- WA, RAA, RAB, Op and Sel are stable across ISSUE and COMMIT. Wen is a single-cycle pulse, only in COMMIT.
- Counters wrap from 2^CNT_W-1 to 0 without saturation.
- rst has priority over a handshake in the same cycle.

Decomposition:
- Package datapath_ctrl_pkg:
  - opcode enum (OP_ADD … OP_NOP)
  - FSM state enum
  - instruction-field bit positions
  - Ctrl bit indices
- Sub-module datapath_ctrl_decode: combinational instr -> {op, writes, sets_flag, ctrl, sel}.
- FSM, latch and counters stay in datapath_controller.

Test Plan:
- ADD 0x0321 (WA=3, RAA=2, RAB=1), Flag=1 in COMMIT -> ISSUE at t+1 with Op=000, RAA=2, RAB=1, Wen=0; COMMIT at t+2 with Wen=1, WA=3; flag_q=1; retired=1.
- EQ 0x2045, Flag=0 -> Wen never asserted; flag_q=0. Then cond ADD 0x8321 -> squashed: Wen=0 for both cycles; squashed=1; retired unchanged.
- LOAD 0x5706 -> Sel=6, Ctrl=0x02, Op=100, Wen=1 in COMMIT, WA=7.
- OUT 0x6050 -> Ctrl[0]=1 only in COMMIT; Wen=0; RAA=5.
- instr_valid held high with 4 NOPs back-to-back -> instr_ready high every 3rd cycle; exactly 4 handshakes in 12 cycles; retired=4.
- rst asserted during COMMIT of ADD -> next cycle all outputs 0, instr_ready=1, flag_q=0, counters=0, no further Wen.

Source files
------------

// File: rtl/datapath_ctrl_pkg.sv
// Shared types and field positions for the datapath sequencer.
// Imported by the decoder and the controller top.
package datapath_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_EQ   = 3'b010,
    OP_AND  = 3'b011,
    OP_MOV  = 3'b100,
    OP_LOAD = 3'b101,
    OP_OUT  = 3'b110,
    OP_NOP  = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  localparam int COND_BIT = 15;
  localparam int OPC_MSB  = 14;
  localparam int OPC_LSB  = 12;
  localparam int WA_MSB   = 11;
  localparam int WA_LSB   = 8;
  localparam int RAA_MSB  = 7;
  localparam int RAA_LSB  = 4;
  localparam int RAB_MSB  = 3;
  localparam int RAB_LSB  = 0;

  localparam int CTRL_OUT_EN  = 0;
  localparam int CTRL_WSRC_IN = 1;

endpackage

// File: rtl/datapath_ctrl_decode.sv
// Combinational opcode decode: ALU op, write/flag classes, Ctrl bits and InPort select.
// Ctrl[0] is reported for OUT here; the controller restricts it to COMMIT.
module datapath_ctrl_decode
  import datapath_ctrl_pkg::*;
(
  input  logic [2:0] opc,
  input  logic [2:0] rab_lo,
  output logic [2:0] op,
  output logic       writes,
  output logic       sets_flag,
  output logic [7:0] ctrl,
  output logic [3:0] sel
);

  always_comb begin
    op        = opc;
    writes    = 1'b0;
    sets_flag = 1'b0;
    ctrl      = '0;
    sel       = '0;
    case (opcode_e'(opc))
      OP_ADD, OP_SUB: begin
        writes    = 1'b1;
        sets_flag = 1'b1;
      end
      OP_AND, OP_MOV: writes = 1'b1;
      OP_EQ:          sets_flag = 1'b1;
      OP_LOAD: begin
        // InPort byte passes through the ALU as a MOV into WA
        writes             = 1'b1;
        op                 = OP_MOV;
        sel                = {1'b0, rab_lo};
        ctrl[CTRL_WSRC_IN] = 1'b1;
      end
      OP_OUT: begin
        op                = OP_MOV;
        ctrl[CTRL_OUT_EN] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/datapath_controller.sv
// Three-state sequencer (IDLE -> ISSUE -> COMMIT) turning 16-bit instructions into
// register-file/ALU controls, with a sticky flag for predicated execution.
module datapath_controller
  import datapath_ctrl_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  input  logic               Flag,
  output logic [2:0]         Op,
  output logic [3:0]         RAA,
  output logic [3:0]         RAB,
  output logic [3:0]         WA,
  output logic               Wen,
  output logic [3:0]         Sel,
  output logic [7:0]         Ctrl,
  output logic               flag_q,
  output logic [CNT_W-1:0]   retired,
  output logic [CNT_W-1:0]   squashed
);

  state_e             state_q, state_d;
  logic [INSTR_W-2:0] instr_p0;
  logic               squash_p0;
  logic               hs;

  logic [2:0] dec_op;
  logic       dec_writes;
  logic       dec_sets_flag;
  logic [7:0] dec_ctrl;
  logic [3:0] dec_sel;

  assign hs = instr_valid && instr_ready;

  datapath_ctrl_decode u_decode (
    .opc       (instr_p0[OPC_MSB:OPC_LSB]),
    .rab_lo    (instr_p0[RAB_LSB+2:RAB_LSB]),
    .op        (dec_op),
    .writes    (dec_writes),
    .sets_flag (dec_sets_flag),
    .ctrl      (dec_ctrl),
    .sel       (dec_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Handshake boundary: instruction word captured, predicate resolved against flag_q now
  always_ff @(posedge clk) begin
    if (hs) instr_p0 <= instr[INSTR_W-2:0];
  end

  always_ff @(posedge clk) begin
    if (rst)     squash_p0 <= 1'b0;
    else if (hs) squash_p0 <= instr[COND_BIT] && !flag_q;
  end

  // Commit boundary: flag capture and retirement accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q   <= 1'b0;
      retired  <= '0;
      squashed <= '0;
    end else if (state_q == ST_COMMIT) begin
      if (squash_p0) begin
        squashed <= squashed + CNT_W'(1);
      end else begin
        retired <= retired + CNT_W'(1);
        if (dec_sets_flag) flag_q <= Flag;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    Op          = '0;
    RAA         = '0;
    RAB         = '0;
    WA          = '0;
    Wen         = 1'b0;
    Sel         = '0;
    Ctrl        = '0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = ST_ISSUE;
      end
      ST_ISSUE, ST_COMMIT: begin
        Op                 = dec_op;
        RAA                = instr_p0[RAA_MSB:RAA_LSB];
        RAB                = instr_p0[RAB_MSB:RAB_LSB];
        WA                 = instr_p0[WA_MSB:WA_LSB];
        Sel                = dec_sel;
        Ctrl[CTRL_WSRC_IN] = dec_ctrl[CTRL_WSRC_IN] && !squash_p0;
        if (state_q == ST_ISSUE) begin
          state_d = ST_COMMIT;
        end else begin
          // rst in COMMIT aborts the instruction before its strobes reach the datapath
          Wen               = dec_writes && !squash_p0 && !rst;
          Ctrl[CTRL_OUT_EN] = dec_ctrl[CTRL_OUT_EN] && !squash_p0 && !rst;
          state_d           = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_datapath_controller.sv
// Directed table-driven bench for datapath_controller plus back-to-back and reset sequences.
module tb_datapath_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        Flag;
  logic [2:0]  Op;
  logic [3:0]  RAA, RAB, WA, Sel;
  logic        Wen;
  logic [7:0]  Ctrl;
  logic        flag_q;
  logic [15:0] retired, squashed;

  int n_cmp  = 0;
  int n_fail = 0;

  datapath_controller #(.INSTR_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .Flag(Flag), .Op(Op), .RAA(RAA), .RAB(RAB),
    .WA(WA), .Wen(Wen), .Sel(Sel), .Ctrl(Ctrl), .flag_q(flag_q),
    .retired(retired), .squashed(squashed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ins;
    logic        flag;
    logic [2:0]  op;
    logic [3:0]  wa, raa, rab, sel;
    logic [7:0]  ctrl_issue, ctrl_commit;
    logic        wen;
    logic        fq;
    logic [15:0] ret, sq;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] pack_out();
    return {Op, RAA, RAB, WA, Wen, Sel, Ctrl};
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int waited = 0;
    while (!instr_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk($sformatf("v%0d_ready", idx), instr_ready, 1'b1);
    instr_valid = 1'b1;
    instr       = v.ins;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    Flag = v.flag;
    chk($sformatf("v%0d_issue", idx), {instr_ready, pack_out()},
        {1'b0, v.op, v.raa, v.rab, v.wa, 1'b0, v.sel, v.ctrl_issue});
    @(negedge clk);
    chk($sformatf("v%0d_commit", idx), {instr_ready, pack_out()},
        {1'b0, v.op, v.raa, v.rab, v.wa, v.wen, v.sel, v.ctrl_commit});
    @(negedge clk);
    chk($sformatf("v%0d_after", idx), {instr_ready, Wen, flag_q, retired, squashed},
        {1'b1, 1'b0, v.fq, v.ret, v.sq});
  endtask

  initial begin
    vec_t sub2;
    int   hs_cnt;

    //        ins       flag  op    wa     raa    rab    sel    ctrlI  ctrlC  wen   fq    ret     sq
    tbl[0]  = '{16'h0321, 1'b1, 3'd0, 4'h3, 4'h2, 4'h1, 4'h0, 8'h00, 8'h00, 1'b1, 1'b1, 16'd1, 16'd0};
    tbl[1]  = '{16'h2045, 1'b0, 3'd2, 4'h0, 4'h4, 4'h5, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 16'd2, 16'd0};
    tbl[2]  = '{16'h8321, 1'b1, 3'd0, 4'h3, 4'h2, 4'h1, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 16'd2, 16'd1};
    tbl[3]  = '{16'h5706, 1'b1, 3'd4, 4'h7, 4'h0, 4'h6, 4'h6, 8'h02, 8'h02, 1'b1, 1'b0, 16'd3, 16'd1};
    tbl[4]  = '{16'h6050, 1'b1, 3'd4, 4'h0, 4'h5, 4'h0, 4'h0, 8'h00, 8'h01, 1'b0, 1'b0, 16'd4, 16'd1};
    tbl[5]  = '{16'h1abc, 1'b1, 3'd1, 4'ha, 4'hb, 4'hc, 4'h0, 8'h00, 8'h00, 1'b1, 1'b1, 16'd5, 16'd1};
    tbl[6]  = '{16'hc512, 1'b0, 3'd4, 4'h5, 4'h1, 4'h2, 4'h0, 8'h00, 8'h00, 1'b1, 1'b1, 16'd6, 16'd1};
    tbl[7]  = '{16'h3fed, 1'b0, 3'd3, 4'hf, 4'he, 4'hd, 4'h0, 8'h00, 8'h00, 1'b1, 1'b1, 16'd7, 16'd1};
    tbl[8]  = '{16'h2000, 1'b0, 3'd2, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 16'd8, 16'd1};
    tbl[9]  = '{16'hd30f, 1'b1, 3'd4, 4'h3, 4'h0, 4'hf, 4'h7, 8'h00, 8'h00, 1'b0, 1'b0, 16'd8, 16'd2};
    tbl[10] = '{16'h7123, 1'b1, 3'd7, 4'h1, 4'h2, 4'h3, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 16'd9, 16'd2};

    // Reset with a pending instruction: reset must win over the handshake
    rst = 1'b1; instr_valid = 1'b1; instr = 16'h0321; Flag = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", {instr_ready, pack_out(), flag_q, retired, squashed}, {1'b1, 28'h0, 1'b0, 16'd0, 16'd0});
    instr_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_no_issue", {instr_ready, pack_out()}, {1'b1, 28'h0});

    for (int i = 0; i < 11; i++) run_vec(tbl[i], i);

    // Back-to-back NOPs with instr_valid held high: one acceptance every third cycle
    hs_cnt = 0;
    instr_valid = 1'b1;
    instr = 16'h7000;
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("b2b_ready_c%0d", c), instr_ready, (c % 3 == 0));
      if (instr_ready && instr_valid) hs_cnt++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("b2b_handshakes", hs_cnt, 4);
    chk("b2b_retired", retired, 16'd13);

    // Set flag_q so the reset clearing it is observable
    sub2 = '{16'h1abc, 1'b1, 3'd1, 4'ha, 4'hb, 4'hc, 4'h0, 8'h00, 8'h00, 1'b1, 1'b1, 16'd14, 16'd2};
    run_vec(sub2, 11);

    // Reset arriving in the COMMIT cycle of an ADD
    instr_valid = 1'b1;
    instr = 16'h0321;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    Flag = 1'b1;
    chk("rst_pre_issue", {Op, RAA, RAB, WA, Wen}, {3'd0, 4'h2, 4'h1, 4'h3, 1'b0});
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rst_commit_wen", {Wen, Ctrl}, {1'b0, 8'h00});
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_after", {instr_ready, pack_out(), flag_q, retired, squashed}, {1'b1, 28'h0, 1'b0, 16'd0, 16'd0});
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst_quiet_c%0d", c), {instr_ready, Wen, retired}, {1'b1, 1'b0, 16'd0});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
